i2c_core_master: RTL

//  Host-side initiator for the I2C core-memory slave: turns one 36-bit core read/write

---
 rtl/i2c_core_master.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/i2c_core_master.sv
// i2c_core_master: turns one 36-bit core read/write request into the I2C byte sequence of the core-memory slave.
// Define I2C_CORE_RETRY_EN to restart the whole transaction after a slave NACK (up to RETRIES times).
module i2c_core_master #(
  parameter logic [6:0] DEVADDR = 7'h2A
`ifdef I2C_CORE_RETRY_EN
  , parameter int RETRIES = 3
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ok,
  input  logic        req,
  input  logic        wr,
  input  logic [17:0] addr,
  input  logic [35:0] wdata,
  output logic [35:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic        phy_start,
  output logic        phy_stop,
  output logic        phy_wr,
  output logic        phy_rd,
  output logic        phy_last,
  output logic [7:0]  phy_tx,
  input  logic [7:0]  phy_rx,
  input  logic        phy_done,
  input  logic        phy_nack
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV, S_ADDR, S_DATA, S_RSTART,
    S_RDEV, S_RDUMMY, S_RDATA, S_STOP, S_DONE
  } state_t;

  state_t      state;
  logic [2:0]  n;
  logic        pend;
  logic        nack_seen;
  logic        wr_q;
  logic [17:0] addr_q;
  logic [35:0] wdata_q;
  logic [35:0] rbuf;
`ifdef I2C_CORE_RETRY_EN
  logic [3:0]  retry_cnt;
`endif

  // Only the low six bits of a received byte carry core data.
  logic unused_rx;
  assign unused_rx = ^phy_rx[7:6];

  function automatic logic [5:0] addr_grp(input logic [17:0] a, input logic [2:0] i);
    logic [17:0] t;
    t = a >> (6 * (2 - i));
    return t[5:0];
  endfunction

  function automatic logic [5:0] data_grp(input logic [35:0] d, input logic [2:0] i);
    logic [35:0] t;
    t = d >> (6 * (5 - i));
    return t[5:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      n         <= '0;
      pend      <= 1'b0;
      nack_seen <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rbuf      <= '0;
      rdata     <= '0;
      ack       <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      phy_start <= 1'b0;
      phy_stop  <= 1'b0;
      phy_wr    <= 1'b0;
      phy_rd    <= 1'b0;
      phy_last  <= 1'b0;
      phy_tx    <= '0;
`ifdef I2C_CORE_RETRY_EN
      retry_cnt <= '0;
`endif
    end else if (ok) begin
      ack       <= 1'b0;
      err       <= 1'b0;
      phy_start <= 1'b0;
      phy_stop  <= 1'b0;
      phy_wr    <= 1'b0;
      phy_rd    <= 1'b0;
      phy_last  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            wr_q      <= wr;
            addr_q    <= addr;
            wdata_q   <= wdata;
            busy      <= 1'b1;
            nack_seen <= 1'b0;
            n         <= '0;
            pend      <= 1'b0;
`ifdef I2C_CORE_RETRY_EN
            retry_cnt <= '0;
`endif
            state     <= S_START;
          end
        end
        S_DONE: begin
          ack   <= 1'b1;
          err   <= nack_seen;
          busy  <= 1'b0;
          if (!wr_q && !nack_seen) rdata <= rbuf;
          state <= S_IDLE;
        end
        default: begin
          if (!pend) begin
            // Issue this step's single command; phy_tx stays put until the next write.
            pend <= 1'b1;
            case (state)
              S_START, S_RSTART: phy_start <= 1'b1;
              S_STOP:            phy_stop  <= 1'b1;
              S_DEV:    begin phy_wr <= 1'b1; phy_tx <= {DEVADDR, 1'b0}; end
              S_RDEV:   begin phy_wr <= 1'b1; phy_tx <= {DEVADDR, 1'b1}; end
              S_ADDR:   begin phy_wr <= 1'b1; phy_tx <= {2'b00, addr_grp(addr_q, n)}; end
              S_DATA:   begin phy_wr <= 1'b1; phy_tx <= {2'b00, data_grp(wdata_q, n)}; end
              S_RDUMMY: phy_rd <= 1'b1;
              S_RDATA:  begin phy_rd <= 1'b1; phy_last <= (n == 3'd5); end
              default: ;
            endcase
          end else if (phy_done) begin
            pend <= 1'b0;
            n    <= '0;
            if (phy_nack && (state == S_DEV || state == S_ADDR ||
                             state == S_DATA || state == S_RDEV)) begin
              nack_seen <= 1'b1;
              state     <= S_STOP;
            end else begin
              case (state)
                S_START:  state <= S_DEV;
                S_DEV:    state <= S_ADDR;
                S_ADDR:   if (n != 3'd2) n <= n + 3'd1;
                          else state <= wr_q ? S_DATA : S_RSTART;
                S_DATA:   if (n != 3'd5) n <= n + 3'd1; else state <= S_STOP;
                S_RSTART: state <= S_RDEV;
                S_RDEV:   state <= S_RDUMMY;
                S_RDUMMY: if (n != 3'd1) n <= n + 3'd1; else state <= S_RDATA;
                S_RDATA: begin
                  rbuf <= {rbuf[29:0], phy_rx[5:0]};
                  if (n != 3'd5) n <= n + 3'd1; else state <= S_STOP;
                end
                S_STOP: begin
`ifdef I2C_CORE_RETRY_EN
                  if (nack_seen && retry_cnt < 4'(RETRIES)) begin
                    retry_cnt <= retry_cnt + 4'd1;
                    nack_seen <= 1'b0;
                    state     <= S_START;
                  end else begin
                    state <= S_DONE;
                  end
`else
                  state <= S_DONE;
`endif
                end
                default: state <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
